// File: rtl/en_reg.sv
// Generic WIDTH-bit state element with write enable and a parameterised async reset value.
// Latency: one clk edge from din to dout; reset takes effect immediately, with no clk edge needed.
// Backpressure: none; wen=0 holds the current value.
module en_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [1023:0]    RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  // The wide parameter zero-fills a short RESET_VAL; the slice drops bits above WIDTH.
  localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];

  generate
    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
      $fatal(1, "en_reg: WIDTH must be in 1..1024");
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= RST_V;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: tb/tb_en_reg.sv
// Directed checks of en_reg: reset, load, hold, async and edge-coincident reset, width rules.
module tb_en_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [31:0] din;
  logic [31:0] dout;
  logic        d1_din;
  logic        d1_dout;
  logic [7:0]  d8_din;
  logic [7:0]  d8_dout;
  logic [39:0] d40_din;
  logic [39:0] d40_dout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  en_reg #(.WIDTH(32), .RESET_VAL(32'h8000_0000)) u_dut32 (
    .clk(clk), .rst(rst), .din(din), .dout(dout), .wen(wen));
  en_reg #(.WIDTH(1), .RESET_VAL(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(d1_din), .dout(d1_dout), .wen(wen));
  en_reg #(.WIDTH(8), .RESET_VAL(12'h1A5)) u_dut8 (
    .clk(clk), .rst(rst), .din(d8_din), .dout(d8_dout), .wen(wen));
  en_reg #(.WIDTH(40), .RESET_VAL(32'h8000_0000)) u_dut40 (
    .clk(clk), .rst(rst), .din(d40_din), .dout(d40_dout), .wen(wen));

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b0;
    wen     = 1'b1;
    din     = 32'h0000_1234;
    d1_din  = 1'b0;
    d8_din  = 8'h00;
    d40_din = '1;

    // Reset held across three enabled edges.
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold32", dout, 40'h0080000000);
      chk("rst_hold1", d1_dout, 40'h1);
      chk("rst_trunc8", d8_dout, 40'hA5);
      chk("rst_zext40", d40_dout, 40'h0080000000);
    end

    // Release does not change dout by itself.
    rst = 1'b1;
    #1;
    chk("release32", dout, 40'h0080000000);

    // Loads, one edge of latency.
    din     = 32'h8000_0004;
    d8_din  = 8'h3C;
    d40_din = 40'hAB_1234_5678;
    @(negedge clk);
    chk("load1_32", dout, 40'h0080000004);
    chk("load_w1", d1_dout, 40'h0);
    chk("load_w8", d8_dout, 40'h3C);
    chk("load_w40", d40_dout, 40'hAB12345678);
    din = 32'h8000_0008;
    #1;
    chk("no_comb_path", dout, 40'h0080000004);
    @(negedge clk);
    chk("load2_32", dout, 40'h0080000008);

    // Hold with wen=0.
    wen    = 1'b0;
    din    = 32'hDEAD_BEEF;
    d1_din = 1'b1;
    d8_din = 8'hFF;
    repeat (4) begin
      @(negedge clk);
      chk("hold32", dout, 40'h0080000008);
    end
    chk("hold_w1", d1_dout, 40'h0);
    chk("hold_w8", d8_dout, 40'h3C);

    // Async reset between edges.
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst32", dout, 40'h0080000000);
    chk("async_rst1", d1_dout, 40'h1);
    chk("async_rst8", d8_dout, 40'hA5);
    @(negedge clk);
    rst = 1'b1;

    // Reset coinciding with an enabled edge: reset wins.
    wen = 1'b1;
    din = 32'hFFFF_FFFF;
    @(posedge clk);
    rst = 1'b0;
    #1;
    chk("edge_rst32", dout, 40'h0080000000);
    @(negedge clk);
    @(negedge clk);
    chk("edge_rst_hold32", dout, 40'h0080000000);
    rst = 1'b1;
    din = 32'h0000_0010;
    @(negedge clk);
    chk("post_rst_load32", dout, 40'h0000000010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
